// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store data memory: size codes,
// response/metadata records, fault detection, byte enables and load extension.
package lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    logic        is_store;
  } lsu_rsp_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] size;
    logic       is_signed;
    logic [1:0] offset;
    logic       fault;
    logic       is_store;
  } lsu_meta_t;

  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_WORD: return off != 2'b00;
      SZ_HALF: return off[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_WORD: return 4'b1111;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: return 4'b0001 << off;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the low store bits across lanes so byte_en alone picks the target.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_HALF: return {wdata[15:0], wdata[15:0]};
      SZ_BYTE: return {4{wdata[7:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic is_signed, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (size)
      SZ_HALF: return {{16{is_signed & h[15]}}, h};
      SZ_BYTE: return {{24{is_signed & b[7]}}, b};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/lsu_datamem_rsp_fifo.sv
// Synchronous response FIFO with a combinationally visible head entry.
module rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slot [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = slot[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) slot[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lsu_datamem.sv
// Pipelined synchronous-read data memory with valid/ready request and
// response ports, byte-lane stores, extended loads and misalignment faults.
module lsu_datamem
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic                  rsp_is_store
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int OW    = $clog2(RSP_DEPTH + 1);

  logic [31:0]           mem [DEPTH];
  logic [OW-1:0]         outstanding;
  logic [ADDR_WIDTH-3:0] widx;
  logic                  accept, fault_req, rsp_hs;
  logic [3:0]            be;
  logic [31:0]           wlanes;

  logic [31:0]           rdata_p [READ_LATENCY];
  lsu_meta_t             meta_p  [READ_LATENCY];

  lsu_meta_t             fin;
  lsu_rsp_t              fin_rsp, fifo_head, out_rsp;
  logic                  fifo_full, fifo_empty, bypass, push, pop;

  assign req_ready = !rst && (outstanding < OW'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign widx      = req_addr[ADDR_WIDTH-1:2];
  assign fault_req = access_fault(req_size, req_addr[1:0]);
  assign be        = byte_en(req_size, req_addr[1:0]);
  assign wlanes    = store_lanes(req_size, req_wdata);

  // Accept edge: store commits and the addressed word is captured into stage 0.
  always_ff @(posedge clk) begin
    if (accept && req_we && !fault_req) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    rdata_p[0] <= mem[widx];
    for (int i = 1; i < READ_LATENCY; i++) rdata_p[i] <= rdata_p[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) meta_p[i].valid <= 1'b0;
    end else begin
      meta_p[0] <= '{valid: accept, size: req_size, is_signed: req_signed,
                     offset: req_addr[1:0], fault: fault_req, is_store: req_we};
      for (int i = 1; i < READ_LATENCY; i++) meta_p[i] <= meta_p[i-1];
    end
  end

  // Final stage: extend, then either hand straight to the consumer or queue.
  assign fin              = meta_p[READ_LATENCY-1];
  assign fin_rsp.rdata    = (fin.fault || fin.is_store) ? 32'h0
                          : load_extend(rdata_p[READ_LATENCY-1], fin.size, fin.is_signed, fin.offset);
  assign fin_rsp.fault    = fin.fault;
  assign fin_rsp.is_store = fin.is_store;

  assign bypass = fifo_empty && rsp_ready;
  assign push   = fin.valid && !bypass && !fifo_full;
  assign pop    = !fifo_empty && rsp_ready;

  rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH ($bits(lsu_rsp_t))
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fin_rsp),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_rsp      = fifo_empty ? fin_rsp : fifo_head;
  assign rsp_valid    = !fifo_empty || fin.valid;
  assign rsp_rdata    = rsp_valid ? out_rsp.rdata : 32'h0;
  assign rsp_fault    = rsp_valid && out_rsp.fault;
  assign rsp_is_store = rsp_valid && out_rsp.is_store;
  assign rsp_hs       = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, rsp_hs})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
